// File: rtl/alu_exec_unit.sv
// Execution unit that takes one request at a time and holds its result in an output register
// with a valid/ready handshake. MUL is iterative shift-add; all other ops finish in one cycle.
module alu_exec_unit #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUop,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       nzcv,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS,
    OP_LSL, OP_LSR, OP_MUL, OP_PASSB, OP_ILL
  } op_t;

  state_t           state, state_next;
  op_t              op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res, load_val;
  logic             alu_ill, set_flags, load, accept, is_mul, mul_done;
  logic [3:0]       flags;

  // Decode
  always_comb begin
    op = OP_ILL;
    case (ALUop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_PASSB;
      2'b10: begin
        case (opcode)
          11'b10001011000: op = OP_ADD;
          11'b11001011000: op = OP_SUB;
          11'b10001010000: op = OP_AND;
          11'b10101010000: op = OP_ORR;
          11'b11001010000: op = OP_EOR;
          11'b10101011000: op = OP_ADDS;
          11'b11101011000: op = OP_SUBS;
          11'b11010011011: op = OP_LSL;
          11'b11010011010: op = OP_LSR;
          11'b10011011000: op = OP_MUL;
          default:         op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Single-cycle datapath; the carry bit of the WIDTH+1 sums is C (no-borrow for SUB)
  always_comb begin
    sum_add   = {1'b0, a} + {1'b0, b};
    sum_sub   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    alu_res   = '0;
    alu_ill   = 1'b0;
    set_flags = 1'b0;
    flags     = '0;
    case (op)
      OP_ADD:   alu_res = sum_add[WIDTH-1:0];
      OP_SUB:   alu_res = sum_sub[WIDTH-1:0];
      OP_AND:   alu_res = a & b;
      OP_ORR:   alu_res = a | b;
      OP_EOR:   alu_res = a ^ b;
      OP_LSL:   alu_res = a << b[SHW-1:0];
      OP_LSR:   alu_res = a >> b[SHW-1:0];
      OP_PASSB: alu_res = b;
      OP_ADDS: begin
        alu_res   = sum_add[WIDTH-1:0];
        set_flags = 1'b1;
        flags     = {sum_add[WIDTH-1], sum_add[WIDTH-1:0] == '0, sum_add[WIDTH],
                     (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1])};
      end
      OP_SUBS: begin
        alu_res   = sum_sub[WIDTH-1:0];
        set_flags = 1'b1;
        flags     = {sum_sub[WIDTH-1], sum_sub[WIDTH-1:0] == '0, sum_sub[WIDTH],
                     (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1])};
      end
      OP_ILL:   alu_ill = 1'b1;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    accept   = in_valid && in_ready;
    is_mul   = (op == OP_MUL);
    mul_done = (state == MUL) && (count == CW'(WIDTH-1));
    acc_next = acc + (mplier[0] ? mcand : '0);
    load     = (accept && !is_mul) || mul_done;
    load_val = mul_done ? acc_next : alu_res;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mul) state_next = MUL;
      MUL:  if (mul_done)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state == MUL);
    in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      nzcv      <= '0;
    end else begin
      if (accept && is_mul) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        count  <= '0;
      end else if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
      // A new load wins over a same-edge transfer out, so out_valid stays high with new data
      if (load) begin
        result    <= load_val;
        zero      <= (load_val == '0);
        illegal   <= !mul_done && alu_ill;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && set_flags) nzcv <= flags;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; power of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 ALUop  input  2  main-decoder op class (00 address add, 01 pass-B/branch-test, 10 R-type, 11 reserved).
REQ-008 opcode  input  11  R-type opcode field, used only when ALUop=10.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 out_valid  output  1  result register holds an undelivered result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered, result==0.
REQ-014 illegal  output  1  registered, set with result of an undecodable request.
REQ-015 nzcv  output  4  architectural flags register {N,Z,C,V}.
REQ-016 busy  output  1  high while in MUL state.

Function
REQ-017 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), allowing back-to-back single-cycle ops.
REQ-019 Decode: ALUop 00 -> ADD; 01 -> PASSB; 10 -> 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR, 11001010000 EOR, 10101011000 ADDS, 11101011000 SUBS, 11010011011 LSL, 11010011010 LSR, 10011011000 MUL.
REQ-020 ALUop 11, or ALUop 10 with any other opcode, SHALL complete in one cycle with result=0, zero=1, illegal=1, nzcv unchanged.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; SUB = a + ~b + 1; LSL/LSR shift a by b[SHW-1:0], zero fill.
REQ-022 Non-MUL ops SHALL load result/zero/illegal and set out_valid on the accepting edge (latency 1).
REQ-023 ADDS/SUBS SHALL update nzcv on the same edge: N=result[WIDTH-1], Z=result==0, C=carry-out of WIDTH-bit add (SUB: carry=no-borrow), V=signed overflow; no other op alters nzcv.
REQ-024 MUL SHALL be iterative shift-add, one multiplier bit per cycle, low WIDTH bits of product kept.
REQ-025 FSM states IDLE, MUL: IDLE->MUL on accepted MUL; MUL stays WIDTH cycles (counter 0..WIDTH-1); on counter==WIDTH-1 edge writes result, sets out_valid, returns to IDLE.
REQ-026 MUL accepted on edge N SHALL present out_valid after edge N+WIDTH; in_ready=0 and busy=1 throughout MUL.
REQ-027 out_valid SHALL clear on transfer out unless a new result loads the same edge, in which case it stays 1 with new data.
REQ-028 result, zero, illegal SHALL hold stable while out_valid && !out_ready.
REQ-029 Inputs a, b, ALUop, opcode SHALL be ignored when no transfer in occurs; MUL operands are captured at acceptance.

Reset
REQ-030 rst high at an edge SHALL force state=IDLE, counter=0, out_valid=0, result=0, zero=0, illegal=0, nzcv=0000, busy=0, aborting any MUL in progress with no result emitted.
REQ-031 in_ready SHALL be 0 in any cycle rst is high; first acceptance is possible on the first edge with rst low.

Verification (WIDTH=8)
REQ-032 ALUop=10 SUBS a=0x05 b=0x05, out_ready=1 -> next cycle result=0x00, zero=1, nzcv=0110.
REQ-033 ADDS a=0x7F b=0x01 -> result=0x80, nzcv=1001; following plain ADD a=0xFF b=0x01 -> result=0x00, zero=1, nzcv still 1001.
REQ-034 MUL a=0x0D b=0x0B accepted edge N -> busy/in_ready=0 for 8 cycles, out_valid after edge N+8, result=0x8F.
REQ-035 out_ready=0 with valid AND result held; in_ready=0 next cycle; raise out_ready with new ORR pending -> both transfers same edge, out_valid stays 1, new data.
REQ-036 ALUop=10 opcode 11111111111 -> result=0x00, illegal=1, nzcv unchanged; LSL a=0x03 b=0x0A -> result=0x0C (shamt 2).
REQ-037 rst asserted 3 cycles into MUL -> after edge: out_valid=0, busy=0, nzcv=0000; no MUL result ever appears.
